// File: rtl/game_ctrl.sv
// game_ctrl: game-status FSM for the stickman runner (lives, score, countdown, respawn, optional pause)
// Ports: Clk, Reset (sync, active-high), frame_clk (frame strobe), StickmanBottom/GroundY (hit detect),
//   keycode (START_KEY starts/restarts, PAUSE_KEY toggles pause); outputs status {waiting,playing,win,lose},
//   paused, respawning, respawn_pulse, run_en, score, lives, countdown (saturated at 255).
// Define GAME_CTRL_PAUSE_EN to include the PAUSE state; without it PAUSE_KEY is ignored and paused is 0.
module game_ctrl #(
  parameter int LIVES = 3,
  parameter int WIN_SCORE = 1000,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int RESPAWN_FRAMES = 120,
  parameter logic [9:0] FALL_Y = 10'd470,
  parameter logic [7:0] START_KEY = 8'h2c,
  parameter logic [7:0] PAUSE_KEY = 8'h13
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  StickmanBottom,
  input  logic [9:0]  GroundY,
  input  logic [7:0]  keycode,
  output logic [3:0]  status,
  output logic        paused,
  output logic        respawning,
  output logic        respawn_pulse,
  output logic        run_en,
  output logic [15:0] score,
  output logic [3:0]  lives,
  output logic [7:0]  countdown
);
  typedef enum logic [2:0] {WAIT, CNTDN, PLAY, RESPAWN, WIN, LOSE, PAUSE} state_t;
  localparam logic [15:0] WS = 16'(WIN_SCORE);
  localparam logic [15:0] CD = 16'(COUNTDOWN_FRAMES);
  localparam logic [15:0] RF = 16'(RESPAWN_FRAMES);
  state_t state;
  logic fc_q;
  logic [7:0] kc_q;
  logic [15:0] cd, rc;
  logic tick, start_p, hit, win;
  assign tick = frame_clk & ~fc_q;
  assign start_p = (keycode == START_KEY) && (kc_q != START_KEY);
  assign hit = (StickmanBottom > GroundY) || (StickmanBottom >= FALL_Y);
  // Win fires either on the stored score or on the tick that reaches the target,
  // so a hit arriving with that tick cannot pre-empt the win.
  assign win = (score == WS) || (tick && (score + 16'd1 == WS));
`ifdef GAME_CTRL_PAUSE_EN
  logic pause_p;
  assign pause_p = (keycode == PAUSE_KEY) && (kc_q != PAUSE_KEY);
  assign paused = state == PAUSE;
`else
  logic unused_pause_key;
  assign unused_pause_key = ^PAUSE_KEY;
  assign paused = 1'b0;
`endif
  assign status = (state == WAIT || state == CNTDN) ? 4'b1000 :
                  (state == WIN) ? 4'b0010 :
                  (state == LOSE) ? 4'b0001 : 4'b0100;
  assign respawning = state == RESPAWN;
  assign run_en = state == PLAY || state == RESPAWN;
  assign countdown = (cd > 16'd255) ? 8'hff : cd[7:0];
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= WAIT;
      fc_q <= 1'b0;
      kc_q <= 8'h00;
      score <= 16'd0;
      lives <= 4'(LIVES);
      cd <= 16'd0;
      rc <= 16'd0;
      respawn_pulse <= 1'b0;
    end else begin
      fc_q <= frame_clk;
      kc_q <= keycode;
      respawn_pulse <= 1'b0;
      case (state)
        WAIT: if (start_p) begin
          score <= 16'd0;
          lives <= 4'(LIVES);
          cd <= CD;
          state <= (CD == 16'd0) ? PLAY : CNTDN;
        end
        CNTDN: if (tick) begin
          cd <= cd - 16'd1;
          if (cd == 16'd1) state <= PLAY;
        end
        PLAY: begin
          if (win) begin
            score <= WS;
            state <= WIN;
          end else if (hit && lives == 4'd1) begin
            lives <= 4'd0;
            state <= LOSE;
          end else if (hit) begin
            lives <= lives - 4'd1;
            rc <= RF;
            respawn_pulse <= 1'b1;
            state <= RESPAWN;
`ifdef GAME_CTRL_PAUSE_EN
          end else if (pause_p) begin
            state <= PAUSE;
`endif
          end else if (tick) begin
            score <= score + 16'd1;
          end
        end
        RESPAWN: begin
          if (win) begin
            score <= WS;
            state <= WIN;
          end else if (tick) begin
            score <= score + 16'd1;
            rc <= rc - 16'd1;
            if (rc == 16'd1) state <= PLAY;
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        PAUSE: if (pause_p) state <= PLAY;
`endif
        WIN, LOSE: if (start_p) state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl
module tb_game_ctrl;
  localparam logic [7:0] SK = 8'h2c;
  localparam logic [7:0] PK = 8'h13;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  logic [9:0] StickmanBottom = 10'd200;
  logic [9:0] GroundY = 10'd250;
  logic [7:0] keycode = 8'h00;
  logic [3:0] status;
  logic paused, respawning, respawn_pulse, run_en;
  logic [15:0] score;
  logic [3:0] lives;
  logic [7:0] countdown;
  int checks = 0;
  int errors = 0;

  game_ctrl #(.LIVES(3), .WIN_SCORE(20), .COUNTDOWN_FRAMES(3), .RESPAWN_FRAMES(4),
              .FALL_Y(10'd470), .START_KEY(SK), .PAUSE_KEY(PK)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .StickmanBottom(StickmanBottom),
    .GroundY(GroundY), .keycode(keycode), .status(status), .paused(paused),
    .respawning(respawning), .respawn_pulse(respawn_pulse), .run_en(run_en),
    .score(score), .lives(lives), .countdown(countdown));

  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      cyc(1);
      frame_clk = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    cyc(1);
    keycode = 8'h00;
    cyc(1);
  endtask

  task automatic hit1();
    StickmanBottom = 10'd300;
    GroundY = 10'd250;
    cyc(1);
    StickmanBottom = 10'd200;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(2);
    Reset = 1'b0;
    chk("rst_status", 16'(status), 16'h8);
    chk("rst_score", score, 0);
    chk("rst_lives", 16'(lives), 3);
    chk("rst_cd", 16'(countdown), 0);
    chk("rst_flags", {12'd0, paused, respawning, respawn_pulse, run_en}, 0);
    press(SK);
    chk("cd3_status", 16'(status), 16'h8);
    chk("cd3", 16'(countdown), 3);
    tick(1);
    chk("cd2", 16'(countdown), 2);
    tick(1);
    chk("cd1", 16'(countdown), 1);
    chk("cd1_status", 16'(status), 16'h8);
    tick(1);
    chk("play_status", 16'(status), 16'h4);
    chk("play_score0", score, 0);
    chk("play_lives", 16'(lives), 3);
    chk("play_run_en", 16'(run_en), 1);
    tick(3);
    chk("score3", score, 3);
    hit1();
    chk("hit_pulse", 16'(respawn_pulse), 1);
    chk("hit_lives", 16'(lives), 2);
    chk("hit_respawning", 16'(respawning), 1);
    chk("hit_status", 16'(status), 16'h4);
    cyc(1);
    chk("pulse_one_cycle", 16'(respawn_pulse), 0);
    StickmanBottom = 10'd480;
    GroundY = 10'd500;
    tick(3);
    chk("immune_lives", 16'(lives), 2);
    chk("immune_respawning", 16'(respawning), 1);
    StickmanBottom = 10'd200;
    GroundY = 10'd250;
    tick(1);
    chk("respawn_done", 16'(respawning), 0);
    chk("respawn_score", score, 7);
    StickmanBottom = 10'd250;
    cyc(2);
    chk("eq_ground_nohit", 16'(lives), 2);
    StickmanBottom = 10'd469;
    GroundY = 10'd500;
    cyc(2);
    chk("below_fall_nohit", 16'(lives), 2);
    StickmanBottom = 10'd470;
    cyc(1);
    StickmanBottom = 10'd200;
    GroundY = 10'd250;
    chk("fall_hit_lives", 16'(lives), 1);
    chk("fall_hit_respawning", 16'(respawning), 1);
    tick(4);
    chk("score11", score, 11);
    chk("play_again", 16'(respawning), 0);
`ifdef GAME_CTRL_PAUSE_EN
    press(PK);
    chk("paused", 16'(paused), 1);
    chk("pause_run_en", 16'(run_en), 0);
    chk("pause_status", 16'(status), 16'h4);
    StickmanBottom = 10'd300;
    tick(3);
    StickmanBottom = 10'd200;
    chk("pause_score_frozen", score, 11);
    chk("pause_lives", 16'(lives), 1);
    press(SK);
    chk("pause_ignores_start", 16'(paused), 1);
    press(PK);
    chk("resumed", 16'(paused), 0);
    keycode = PK;
    cyc(20);
    keycode = 8'h00;
    cyc(1);
    chk("held_pause_once", 16'(paused), 1);
    press(PK);
    chk("resumed2", 16'(paused), 0);
`else
    press(PK);
    chk("nopause_paused", 16'(paused), 0);
    chk("nopause_run_en", 16'(run_en), 1);
    keycode = PK;
    cyc(20);
    keycode = 8'h00;
    cyc(1);
    chk("nopause_held", 16'(paused), 0);
`endif
    tick(8);
    chk("score19", score, 19);
    chk("pre_win_status", 16'(status), 16'h4);
    frame_clk = 1'b1;
    StickmanBottom = 10'd300;
    cyc(1);
    frame_clk = 1'b0;
    StickmanBottom = 10'd200;
    cyc(1);
    chk("win_status", 16'(status), 16'h2);
    chk("win_score", score, 20);
    chk("win_lives", 16'(lives), 1);
    tick(1);
    chk("win_score_held", score, 20);
    press(SK);
    chk("win_to_wait", 16'(status), 16'h8);
    press(SK);
    chk("restart_cd", 16'(countdown), 3);
    tick(3);
    chk("restart_play", 16'(status), 16'h4);
    chk("restart_score", score, 0);
    chk("restart_lives", 16'(lives), 3);
    hit1();
    chk("l3_to_2", 16'(lives), 2);
    tick(4);
    hit1();
    chk("l2_to_1", 16'(lives), 1);
    tick(4);
    hit1();
    chk("l1_to_0", 16'(lives), 0);
    chk("lose_status", 16'(status), 16'h1);
    chk("lose_no_pulse", 16'(respawn_pulse), 0);
    chk("lose_run_en", 16'(run_en), 0);
    chk("lose_score", score, 8);
    keycode = SK;
    cyc(1);
    chk("lose_to_wait", 16'(status), 16'h8);
    cyc(49);
    chk("held_start_wait", 16'(status), 16'h8);
    chk("held_start_cd", 16'(countdown), 0);
    keycode = 8'h00;
    cyc(1);
    press(SK);
    chk("repress_cd", 16'(countdown), 3);
    tick(3);
    hit1();
    chk("pre_reset_resp", 16'(respawning), 1);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    chk("mid_reset_status", 16'(status), 16'h8);
    chk("mid_reset_lives", 16'(lives), 3);
    chk("mid_reset_flags", {12'd0, paused, respawning, respawn_pulse, run_en}, 0);
    chk("mid_reset_score", score, 0);
    frame_clk = 1'b1;
    keycode = SK;
    cyc(1);
    frame_clk = 1'b0;
    keycode = 8'h00;
    cyc(1);
    chk("key_beats_tick", 16'(countdown), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
